// File: rtl/key_pkg.sv
// Shared key codes, debounce state type and button encoder for the arrow-key front-end.
package key_pkg;

  localparam logic [3:0] KEY_NONE    = 4'h0;
  localparam logic [3:0] KEY_UP      = 4'h1;
  localparam logic [3:0] KEY_DOWN    = 4'h2;
  localparam logic [3:0] KEY_LEFT    = 4'h3;
  localparam logic [3:0] KEY_RIGHT   = 4'h4;
  localparam logic [3:0] KEY_START   = 4'h5;
  localparam logic [3:0] KEY_CHORD   = 4'hE;
  localparam logic [3:0] KEY_SEQ_END = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_QUAL_PRESS,
    ST_HELD,
    ST_QUAL_RELEASE
  } deb_state_t;

  // One-hot button vector to key code; any multi-bit pattern is a chord.
  // KEY_SEQ_END is reserved for the key-match FSM and never produced here.
  function automatic logic [3:0] encode_keys(input logic [4:0] b);
    case (b)
      5'b00000: encode_keys = KEY_NONE;
      5'b00001: encode_keys = KEY_UP;
      5'b00010: encode_keys = KEY_DOWN;
      5'b00100: encode_keys = KEY_LEFT;
      5'b01000: encode_keys = KEY_RIGHT;
      5'b10000: encode_keys = KEY_START;
      default:  encode_keys = KEY_CHORD;
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchroniser; resets to 0 (released).
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_input_debounce.sv
// Synchronise, encode and debounce five push buttons into a 4-bit key code.
// Build option KEY_BTN_ACTIVE_LOW_EN: buttons are pulled up (0 = pressed).
module key_input_debounce
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 400000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] btn,
  output logic [3:0] key_pressed,
  output logic       key_pulse,
  output logic       key_busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [4:0]       btn_in;
  logic [4:0]       s_btn;
  logic [3:0]       raw_code;
  logic [3:0]       cand;
  logic [CNT_W-1:0] cnt;
  deb_state_t       state;

`ifdef KEY_BTN_ACTIVE_LOW_EN
  assign btn_in = ~btn;
`else
  assign btn_in = btn;
`endif

  // Per-bit synchronisers into the clk domain.
  for (genvar i = 0; i < 5; i++) begin : g_sync
    sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (btn_in[i]),
      .q     (s_btn[i])
    );
  end

  assign raw_code = encode_keys(s_btn);

  // Debounce FSM: a code must hold DEBOUNCE_CYCLES to press, its absence the same to release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cand        <= KEY_NONE;
      cnt         <= '0;
      key_pressed <= KEY_NONE;
      key_pulse   <= 1'b0;
    end else begin
      key_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          key_pressed <= KEY_NONE;
          if (raw_code != KEY_NONE) begin
            state <= ST_QUAL_PRESS;
            cand  <= raw_code;
            cnt   <= '0;
          end
        end
        ST_QUAL_PRESS: begin
          key_pressed <= KEY_NONE;
          if (raw_code == KEY_NONE) begin
            state <= ST_IDLE;
          end else if (raw_code != cand) begin
            cand <= raw_code;
            cnt  <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= ST_HELD;
            key_pressed <= cand;
            key_pulse   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_HELD: begin
          key_pressed <= cand;
          if (raw_code != cand) begin
            state <= ST_QUAL_RELEASE;
            cnt   <= '0;
          end
        end
        ST_QUAL_RELEASE: begin
          // Any code other than cand counts toward release, forcing a 0 gap between keys.
          if (raw_code == cand) begin
            state <= ST_HELD;
          end else if (cnt == CNT_LAST) begin
            state       <= ST_IDLE;
            key_pressed <= KEY_NONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state       <= ST_IDLE;
          key_pressed <= KEY_NONE;
        end
      endcase
    end
  end

  assign key_busy = (state == ST_QUAL_PRESS) || (state == ST_QUAL_RELEASE);

endmodule

// File: tb/tb_key_input_debounce.sv
// Scoreboard bench for key_input_debounce against a run-length reference model.
module tb_key_input_debounce;

  localparam int N = 4;

  typedef struct {
    logic [3:0] key;
    logic       pulse;
    logic       busy;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [4:0] btn;
  logic [3:0] key_pressed;
  logic       key_pulse;
  logic       key_busy;

  int checks = 0;
  int errors = 0;
  int dut_pulses = 0;
  exp_t q[$];

  // Reference model state: sync pipeline plus consecutive-sample run counters.
  logic [4:0] p1, p2;
  bit         m_held;
  logic [3:0] m_code;
  int         m_run, m_miss;

  key_input_debounce #(.DEBOUNCE_CYCLES(N), .CNT_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn         (btn),
    .key_pressed (key_pressed),
    .key_pulse   (key_pulse),
    .key_busy    (key_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] drv(input logic [4:0] v);
`ifdef KEY_BTN_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  function automatic logic [3:0] ref_code(input logic [4:0] b);
    int k;
    logic [3:0] c;
    k = $countones(b);
    c = 4'h0;
    if (k > 1) return 4'hE;
    for (int i = 0; i < 5; i++) if (b[i]) c = 4'(i + 1);
    return c;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    p1 = '0; p2 = '0; m_held = 0; m_code = '0; m_run = 0; m_miss = 0;
  endtask

  // Advance the model by one clock edge given the logical button value driven before it.
  task automatic model_edge(input logic [4:0] v);
    logic [3:0] c;
    exp_t e;
    c = ref_code(p2);
    p2 = p1;
    p1 = v;
    e.pulse = 1'b0;
    if (!m_held) begin
      if (c == 4'h0) m_run = 0;
      else if (m_run > 0 && c == m_code) m_run++;
      else begin m_code = c; m_run = 1; end
      if (m_run == N + 1) begin m_held = 1; m_miss = 0; e.pulse = 1'b1; end
    end else begin
      if (c == m_code) m_miss = 0;
      else m_miss++;
      if (m_miss == N + 1) begin m_held = 0; m_run = 0; end
    end
    e.key  = m_held ? m_code : 4'h0;
    e.busy = m_held ? (m_miss > 0) : (m_run > 0);
    q.push_back(e);
  endtask

  task automatic cyc(input logic [4:0] v, input int n);
    repeat (n) begin
      @(negedge clk);
      btn = drv(v);
      model_edge(v);
    end
  endtask

  // Asynchronous reset between edges, held for n edges, released with v still driven.
  task automatic do_reset(input logic [4:0] v, input int n);
    exp_t z;
    z.key = 4'h0; z.pulse = 1'b0; z.busy = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("reset_key", int'(key_pressed), 0);
    check("reset_pulse", int'(key_pulse), 0);
    check("reset_busy", int'(key_busy), 0);
    q.delete();
    model_clear();
    q.push_back(z);
    repeat (n) begin
      @(negedge clk);
      btn = drv(v);
      q.push_back(z);
    end
    @(negedge clk);
    reset = 1'b0;
    btn = drv(v);
    model_edge(v);
  endtask

  // Monitor: compare DUT outputs after every edge against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (key_pulse) dut_pulses++;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("key_pressed", int'(key_pressed), int'(e.key));
        check("key_pulse", int'(key_pulse), int'(e.pulse));
        check("key_busy", int'(key_busy), int'(e.busy));
      end
    end
  end

  initial begin
    int p0;
    logic [4:0] v;
    reset = 1'b1;
    btn = drv(5'b00000);
    model_clear();
    #3;
    check("init_key", int'(key_pressed), 0);
    check("init_pulse", int'(key_pulse), 0);
    check("init_busy", int'(key_busy), 0);
    @(negedge clk);
    reset = 1'b0;
    model_edge(5'b00000);
    cyc(5'b00000, 3);

    // Clean LEFT press and release.
    p0 = dut_pulses;
    cyc(5'b00100, 20);
    check("left_key_held", int'(key_pressed), 3);
    cyc(5'b00000, 10);
    check("left_pulses", dut_pulses - p0, 1);

    // Bouncing UP, then stable.
    p0 = dut_pulses;
    for (int i = 0; i < 5; i++) cyc((i % 2 == 0) ? 5'b00001 : 5'b00000, 2);
    check("bounce_no_pulse", dut_pulses - p0, 0);
    cyc(5'b00001, 15);
    cyc(5'b00000, 10);
    check("bounce_pulses", dut_pulses - p0, 1);

    // Chord then direct switch to DOWN.
    p0 = dut_pulses;
    cyc(5'b00011, 15);
    check("chord_key", int'(key_pressed), 14);
    cyc(5'b00010, 20);
    check("down_key", int'(key_pressed), 2);
    cyc(5'b00000, 10);
    check("chord_pulses", dut_pulses - p0, 2);

    // Short release glitch while RIGHT is held.
    p0 = dut_pulses;
    cyc(5'b01000, 15);
    cyc(5'b00000, 2);
    cyc(5'b01000, 10);
    check("glitch_key", int'(key_pressed), 4);
    cyc(5'b00000, 10);
    check("glitch_pulses", dut_pulses - p0, 1);

    // Reset while START is held, then re-qualify.
    cyc(5'b10000, 15);
    check("start_key", int'(key_pressed), 5);
    do_reset(5'b10000, 2);
    p0 = dut_pulses;
    cyc(5'b10000, 15);
    check("start_requal_key", int'(key_pressed), 5);
    check("start_requal_pulses", dut_pulses - p0, 1);
    cyc(5'b00000, 10);

    // Random segments biased toward single keys and idle.
    for (int s = 0; s < 120; s++) begin
      case ($urandom_range(0, 3))
        0: v = 5'b00000;
        1, 2: v = 5'(1 << $urandom_range(0, 4));
        default: v = 5'($urandom_range(0, 31));
      endcase
      cyc(v, int'($urandom_range(1, 9)));
    end
    cyc(5'b00000, 12);
    check("final_key", int'(key_pressed), 0);

    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
